pht_update_ctrl: RTL and testbench
==================================

Name: pht_update_ctrl

Overview:
- Sequences all writes into the global pattern-history counter table (N x 2-bit, indexed by BHR).
- Runs a one-entry-per-cycle init sweep after reset or on request.
- Buffers branch resolutions from EX in a small FIFO and drains one update per cycle when the table write port is free.
- Sits between the EX-stage branch resolution logic and the PHT storage; the table itself performs the saturating increment/decrement.

Parameters:
- N, 128, number of PHT entries; power of 2, >=4; index width n = $clog2(N).
- QDEPTH, 4, resolution FIFO depth; power of 2, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- res_valid  in  1  a branch resolved in EX this cycle
- res_taken  in  1  resolved direction (cmp_out_ex)
- res_idx  in  n  BHR snapshot carried with the branch (bhr_ex)
- res_ready  out  1  FIFO can accept a resolution
- init_req  in  1  single-cycle pulse: re-initialise the table
- pht_busy  in  1  table write port unavailable this cycle (updates only)
- pht_we  out  1  write strobe to the table
- pht_idx  out  n  entry to write
- pht_init  out  1  1 = write constant 2'b01; 0 = saturating update
- pht_taken  out  1  update direction: 1 = increment, 0 = decrement; 0 when pht_init=1
- busy  out  1  init sweep in progress
- q_count  out  $clog2(QDEPTH+1)  FIFO occupancy

Behaviour:
- Clocking: single clock; reset is synchronous, active-low, sampled on posedge clk.
- While rst_n=0: pht_we=0, res_ready=0, busy=1, q_count=0; FSM goes to INIT, sweep_idx=0, FIFO emptied.
- FSM has two states, INIT and RUN.
- INIT:
  - pht_we=1, pht_init=1, pht_idx=sweep_idx; sweep_idx increments every cycle.
  - pht_busy is ignored; the sweep has absolute priority.
  - busy=1, res_ready=0; res_valid is ignored.
  - After the cycle with sweep_idx=N-1, go to RUN and clear sweep_idx. The sweep is exactly N cycles.
- RUN:
  - busy=0; res_ready = (q_count != QDEPTH).
  - Enqueue {res_idx, res_taken} when res_valid && res_ready.
  - Head issue is combinational: pht_we = (q_count != 0) && !pht_busy; pht_idx/pht_taken come from the FIFO head; pht_init=0.
  - Dequeue when pht_we=1. Latency from enqueue to write is at least 1 cycle.
- Full FIFO: res_ready=0 even if a dequeue occurs in the same cycle (no pass-through when full). A res_valid seen while res_ready=0 is a protocol violation, is dropped, and leaves state unchanged.
- Simultaneous enqueue and dequeue with 0 < q_count < QDEPTH: q_count is unchanged and order is preserved. FIFO is strictly in order.
- Pointers wrap modulo QDEPTH.
- Duplicate indices are not merged; each is issued separately.
- init_req in RUN: the FIFO is flushed the next cycle (pending updates are discarded), then INIT starts at idx 0. Any update issued in the init_req cycle still completes.
- init_req during INIT: the sweep restarts at idx 0.
- init_req and res_valid in the same cycle: the resolution is discarded.
- Reset mid-sweep or mid-drain: returns to the reset state above; no partial state survives.

Optional Feature:
- Macro: PHT_UPD_BYPASS_EN.
- Defined: in RUN with q_count=0, res_valid=1 and pht_busy=0, the resolution drives pht_* combinationally in the same cycle and is not enqueued (0-cycle latency). If pht_busy=1 it is enqueued normally.
- Undefined: every resolution passes through the FIFO, giving a minimum 1-cycle latency.

Decomposition:
- Shared package bp_pkg holds:
  - PHT_INIT_VAL = 2'b01
  - typedef pht_upd_t {idx, taken}
  - enum pht_ctrl_state_e {INIT, RUN}
- Sub-module bp_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) holds the resolution queue. The FSM and sweep counter stay in pht_update_ctrl.

Test Plan:
- Release reset, N=128: pht_we=1, pht_init=1, pht_idx = 0..127 on 128 consecutive cycles; busy falls and res_ready=1 on cycle 129; no write while rst_n=0.
- In RUN, push (idx=5, T), (idx=5, NT), (idx=9, T) back-to-back with pht_busy=0: writes idx 5/T, 5/NT, 9/T in order, each 1 cycle after its enqueue; q_count never exceeds 1.
- Hold pht_busy=1 and push 4 resolutions: q_count=4 and res_ready=0; a 5th res_valid is dropped. Drop pht_busy: 4 writes in order, then pht_we=0.
- Queue 3 entries, pulse init_req: at most 1 update is written, then a 128-cycle sweep from idx 0; q_count=0 afterwards; a 2nd init_req mid-sweep at idx 40 restarts at idx 0.
- Assert rst_n=0 at sweep idx 70 with 2 queued entries: pht_we=0 during reset, then a fresh sweep from idx 0; the queued entries are never written.
- With PHT_UPD_BYPASS_EN defined, an empty FIFO and res_valid (idx=3, T): pht_we=1, pht_idx=3 in the same cycle and q_count stays 0. Without the macro, the write occurs the next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types for the pattern-history table update path.
package bp_pkg;

    localparam int unsigned PHT_N        = 128;
    localparam int unsigned PHT_IDX_W    = $clog2(PHT_N);
    localparam logic [1:0]  PHT_INIT_VAL = 2'b01;

    typedef struct packed {
        logic [PHT_IDX_W-1:0] idx;
        logic                 taken;
    } pht_upd_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pht_ctrl_state_e;

endpackage

// File: rtl/bp_sync_fifo.sv
// Strictly in-order synchronous FIFO with synchronous flush; used for the branch resolution queue.
module bp_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are power-of-two wide, so increment wraps modulo DEPTH.
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pht_update_ctrl.sv
// Sequences PHT writes: init sweep after reset/init_req, then in-order drain of EX resolutions.
// Optional same-cycle bypass of an empty queue is enabled by defining PHT_UPD_BYPASS_EN.
module pht_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned N      = 128,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          res_valid,
    input  logic                          res_taken,
    input  logic [$clog2(N)-1:0]          res_idx,
    output logic                          res_ready,
    input  logic                          init_req,
    input  logic                          pht_busy,
    output logic                          pht_we,
    output logic [$clog2(N)-1:0]          pht_idx,
    output logic                          pht_init,
    output logic                          pht_taken,
    output logic                          busy,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned CntW = $clog2(QDEPTH + 1);

    pht_ctrl_state_e  state_q, state_d;
    logic [IdxW-1:0]  sweep_q, sweep_d;

    logic             run, bypass, issue;
    logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [IdxW:0]    fifo_head;
    logic [CntW-1:0]  fifo_count;

    assign run        = rst_n && (state_q == RUN);
    assign res_ready  = run && !fifo_full;
    assign issue      = run && !fifo_empty && !pht_busy;

`ifdef PHT_UPD_BYPASS_EN
    assign bypass     = run && fifo_empty && res_valid && !pht_busy && !init_req;
`else
    assign bypass     = 1'b0;
`endif

    // A resolution arriving with init_req is discarded along with the queue.
    assign fifo_push  = res_valid && res_ready && !init_req && !bypass;
    assign fifo_pop   = issue;
    assign fifo_flush = (state_q == RUN) && init_req;

    bp_sync_fifo #(
        .WIDTH (IdxW + 1),
        .DEPTH (QDEPTH)
    ) u_res_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i ({res_idx, res_taken}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == IdxW'(N - 1)) state_d = RUN;
        end
        if (init_req) begin
            state_d = INIT;
            sweep_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        pht_we    = 1'b0;
        pht_idx   = '0;
        pht_init  = 1'b0;
        pht_taken = 1'b0;
        if (!rst_n) begin
            pht_we = 1'b0;
        end else if (state_q == INIT) begin
            pht_we   = 1'b1;
            pht_init = 1'b1;
            pht_idx  = sweep_q;
        end else if (issue) begin
            pht_we    = 1'b1;
            pht_idx   = fifo_head[IdxW:1];
            pht_taken = fifo_head[0];
        end else if (bypass) begin
            pht_we    = 1'b1;
            pht_idx   = res_idx;
            pht_taken = res_taken;
        end
    end

    assign busy    = !rst_n || (state_q == INIT);
    assign q_count = rst_n ? fifo_count : '0;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Scoreboard bench for pht_update_ctrl; expected update writes are queued at drive time.
module tb_pht_update_ctrl;
    import bp_pkg::*;

    localparam int unsigned N      = 128;
    localparam int unsigned QDEPTH = 4;
`ifdef PHT_UPD_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_taken = 1'b0;
    logic [6:0] res_idx = '0;
    logic       init_req = 1'b0;
    logic       pht_busy = 1'b0;
    logic       res_ready, pht_we, pht_init, pht_taken, busy;
    logic [6:0] pht_idx;
    logic [2:0] q_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        pht_upd_t upd;
        int       cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    pht_update_ctrl #(
        .N      (N),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_taken (res_taken),
        .res_idx   (res_idx),
        .res_ready (res_ready),
        .init_req  (init_req),
        .pht_busy  (pht_busy),
        .pht_we    (pht_we),
        .pht_idx   (pht_idx),
        .pht_init  (pht_init),
        .pht_taken (pht_taken),
        .busy      (busy),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every non-init write must match the oldest expected update (and its cycle, when known).
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pht_we === 1'b1 && pht_init === 1'b0) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got idx=%0d taken=%0b at cycle %0d, expected no write",
                         pht_idx, pht_taken, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (pht_idx !== mon_e.upd.idx || pht_taken !== mon_e.upd.taken ||
                    (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    n_fail++;
                    $display("FAIL update_write: got idx=%0d taken=%0b cycle=%0d, expected idx=%0d taken=%0b cycle=%0d",
                             pht_idx, pht_taken, cyc, mon_e.upd.idx, mon_e.upd.taken, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_upd(input logic [6:0] idx, input logic tk, input int c);
        exp_t e;
        e.upd.idx   = idx;
        e.upd.taken = tk;
        e.cyc       = c;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pht_busy = 1'b1; res_valid = 1'b1; res_idx = 7'd11; res_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pht_we !== 1'b0 || busy !== 1'b1 || res_ready !== 1'b0 || q_count !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got we=%b busy=%b ready=%b q=%0d, expected 0 1 0 0",
                         pht_we, busy, res_ready, q_count);
            end
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            n_checks++;
            if (pht_we !== 1'b1 || pht_init !== 1'b1 || pht_idx !== 7'(i) || pht_taken !== 1'b0 ||
                busy !== 1'b1 || res_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_sweep: got we=%b init=%b idx=%0d tk=%b busy=%b ready=%b, expected 1 1 %0d 0 1 0",
                         pht_we, pht_init, pht_idx, pht_taken, busy, res_ready, i);
            end
            step();
        end
        res_valid = 1'b0; pht_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || res_ready !== 1'b1 || pht_we !== 1'b0 || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_run_entry: got busy=%b ready=%b we=%b q=%0d, expected 0 1 0 0",
                     busy, res_ready, pht_we, q_count);
        end
        step();
    endtask

    task automatic test_in_order();
        logic [6:0] idxs [3] = '{7'd5, 7'd5, 7'd9};
        logic       tks  [3] = '{1'b1, 1'b0, 1'b1};
        pht_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            res_valid = (i < 3);
            if (i < 3) begin
                res_idx = idxs[i]; res_taken = tks[i];
                expect_upd(idxs[i], tks[i], cyc + LAT);
            end
            @(negedge clk);
            n_checks++;
            if (q_count > 3'd1) begin
                n_fail++;
                $display("FAIL inorder_qcount: got q=%0d, expected <= 1", q_count);
            end
            step();
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL inorder_drained: got %0d pending, expected 0", sb_q.size());
        end
    endtask

    task automatic test_full();
        pht_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_idx = 7'(20 + i); res_taken = i[0];
            expect_upd(7'(20 + i), i[0], -1);
            @(negedge clk);
            n_checks++;
            if (res_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL full_ready_before: got ready=%b at q=%0d, expected 1", res_ready, q_count);
            end
            step();
        end
        res_valid = 1'b1; res_idx = 7'd77; res_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (q_count !== 3'd4 || res_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_count: got q=%0d ready=%b, expected 4 0", q_count, res_ready);
        end
        step();
        res_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (q_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_drop_ignored: got q=%0d, expected 4", q_count);
        end
        step();
        pht_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (res_ready !== 1'b0 || pht_we !== 1'b1) begin
            n_fail++;
            $display("FAIL full_no_passthrough: got ready=%b we=%b, expected 0 1", res_ready, pht_we);
        end
        step();
        for (int k = 0; k < 8 && sb_q.size() != 0; k++) begin
            @(negedge clk);
            step();
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_drained: got %0d pending after cycle budget, expected 0", sb_q.size());
        end
        @(negedge clk);
        n_checks++;
        if (pht_we !== 1'b0 || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL full_idle: got we=%b q=%0d, expected 0 0", pht_we, q_count);
        end
        step();
    endtask

    task automatic test_init_flush();
        pht_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_idx = 7'(40 + i); res_taken = 1'b1;
            expect_upd(7'(40 + i), 1'b1, -1);
            @(negedge clk);
            step();
        end
        res_valid = 1'b1; res_idx = 7'd100; init_req = 1'b1; pht_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pht_we !== 1'b1 || pht_init !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_issue: got we=%b init=%b, expected 1 0", pht_we, pht_init);
        end
        step();
        init_req = 1'b0; res_valid = 1'b0;
        sb_q.delete();
        for (int i = 0; i <= 40; i++) begin
            init_req = (i == 40);
            @(negedge clk);
            n_checks++;
            if (pht_we !== 1'b1 || pht_init !== 1'b1 || pht_idx !== 7'(i) || q_count !== 3'd0) begin
                n_fail++;
                $display("FAIL flush_sweep: got we=%b init=%b idx=%0d q=%0d, expected 1 1 %0d 0",
                         pht_we, pht_init, pht_idx, q_count, i);
            end
            step();
        end
        init_req = 1'b0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            n_checks++;
            if (pht_we !== 1'b1 || pht_init !== 1'b1 || pht_idx !== 7'(i)) begin
                n_fail++;
                $display("FAIL restart_sweep: got we=%b init=%b idx=%0d, expected 1 1 %0d",
                         pht_we, pht_init, pht_idx, i);
            end
            step();
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || q_count !== 3'd0 || pht_we !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: got busy=%b q=%0d we=%b, expected 0 0 0", busy, q_count, pht_we);
        end
        step();
    endtask

    task automatic test_reset_mid();
        pht_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            res_valid = 1'b1; res_idx = 7'(60 + i); res_taken = 1'b0;
            @(negedge clk);
            step();
        end
        res_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (q_count !== 3'd2) begin
            n_fail++;
            $display("FAIL rstmid_queued: got q=%0d, expected 2", q_count);
        end
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (pht_we !== 1'b0 || q_count !== 3'd0 || busy !== 1'b1 || res_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_drain_reset: got we=%b q=%0d busy=%b ready=%b, expected 0 0 1 0",
                         pht_we, q_count, busy, res_ready);
            end
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            step();
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (pht_we !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_sweep_reset: got we=%b, expected 0", pht_we);
            end
            step();
        end
        rst_n = 1'b1; pht_busy = 1'b0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            n_checks++;
            if (pht_we !== 1'b1 || pht_init !== 1'b1 || pht_idx !== 7'(i)) begin
                n_fail++;
                $display("FAIL rstmid_fresh_sweep: got we=%b init=%b idx=%0d, expected 1 1 %0d",
                         pht_we, pht_init, pht_idx, i);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pht_we !== 1'b0 || q_count !== 3'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_idle: got we=%b q=%0d busy=%b, expected 0 0 0", pht_we, q_count, busy);
            end
            step();
        end
    endtask

    task automatic test_bypass();
        pht_busy = 1'b0; res_valid = 1'b1; res_idx = 7'd3; res_taken = 1'b1;
        expect_upd(7'd3, 1'b1, cyc + LAT);
        @(negedge clk);
        n_checks++;
`ifdef PHT_UPD_BYPASS_EN
        if (pht_we !== 1'b1 || pht_idx !== 7'd3 || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got we=%b idx=%0d q=%0d, expected 1 3 0", pht_we, pht_idx, q_count);
        end
`else
        if (pht_we !== 1'b0 || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL nobypass_first: got we=%b q=%0d, expected 0 0", pht_we, q_count);
        end
`endif
        step();
        res_valid = 1'b0;
        @(negedge clk);
        n_checks++;
`ifdef PHT_UPD_BYPASS_EN
        if (pht_we !== 1'b0 || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_after: got we=%b q=%0d, expected 0 0", pht_we, q_count);
        end
`else
        if (pht_we !== 1'b1 || pht_idx !== 7'd3 || q_count !== 3'd1) begin
            n_fail++;
            $display("FAIL nobypass_next: got we=%b idx=%0d q=%0d, expected 1 3 1", pht_we, pht_idx, q_count);
        end
`endif
        step();
        @(negedge clk);
        n_checks++;
        if (q_count !== 3'd0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bypass_drained: got q=%0d pending=%0d, expected 0 0", q_count, sb_q.size());
        end
        step();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_init_flush();
        test_reset_mid();
        test_bypass();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
